// File: rtl/wb_commit_pkg.sv
// Shared widths, types and helpers for the write-back commit unit.
package wb_commit_pkg;

    localparam int REG_AW = 5;
    localparam int REG_W  = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_W-1:0]  reg_data_t;

    localparam reg_addr_t ZERO_ADDR = '0;
    localparam reg_data_t ZERO_WORD = '0;

    // Register 0 is hard-wired; writes to it are meaningless and never tracked.
    function automatic logic addr_nonzero(input reg_addr_t a);
        return a != ZERO_ADDR;
    endfunction

endpackage

// File: rtl/wb_commit_lr_queue.sv
// Circular buffer of long-latency results. Entries can be squashed in place
// (valid cleared, slot kept) so arrival order and occupancy stay intact.
module wb_lr_queue
    import wb_commit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  reg_addr_t       push_addr_i,
    input  reg_data_t       push_data_i,
    input  logic            pop_i,
    input  logic            squash_i,
    input  reg_addr_t       squash_addr_i,
    input  reg_addr_t       match1_addr_i,
    input  reg_addr_t       match2_addr_i,
    output logic            head_valid_o,
    output logic            head_occupied_o,
    output reg_addr_t       head_addr_o,
    output reg_data_t       head_data_o,
    output logic            full_o,
    output logic [CW-1:0]   count_o,
    output logic            match1_o,
    output logic            match2_o
);

    logic [DEPTH-1:0] valid_q, valid_d;
    reg_addr_t        addr_q [DEPTH];
    reg_data_t        data_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             m1, m2;

    // Valid bits: squash first, then pop/push; the incoming entry is never squashed.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (squash_i && addr_q[i] == squash_addr_i) valid_d[i] = 1'b0;
        end
        if (pop_i)  valid_d[rd_ptr_q] = 1'b0;
        if (push_i) valid_d[wr_ptr_q] = 1'b1;
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= ZERO_ADDR;
                data_q[i] <= ZERO_WORD;
            end
        end else begin
            valid_q <= valid_d;
            if (push_i) begin
                addr_q[wr_ptr_q] <= push_addr_i;
                data_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Hazard match ports: only live (unsquashed) entries count.
    always_comb begin
        m1 = 1'b0;
        m2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == match1_addr_i) m1 = 1'b1;
            if (valid_q[i] && addr_q[i] == match2_addr_i) m2 = 1'b1;
        end
    end

    assign match1_o        = m1 & addr_nonzero(match1_addr_i);
    assign match2_o        = m2 & addr_nonzero(match2_addr_i);
    assign head_valid_o    = valid_q[rd_ptr_q];
    assign head_occupied_o = count_q != '0;
    assign head_addr_o     = addr_q[rd_ptr_q];
    assign head_data_o     = data_q[rd_ptr_q];
    assign full_o          = count_q == CW'(DEPTH);
    assign count_o         = count_q;

endmodule

// File: rtl/wb_commit.sv
// Write-back commit unit: sole driver of the register-file write port.
// Pipeline results win; queued long-latency results fill idle cycles.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_wreg,
    input  reg_addr_t       mem_wd,
    input  reg_data_t       mem_wdata,
    input  logic            wb_stall,
    input  logic            lr_valid,
    input  reg_addr_t       lr_waddr,
    input  reg_data_t       lr_wdata,
    output logic            lr_ready,
    output logic            we,
    output reg_addr_t       waddr,
    output reg_data_t       wdata,
    input  reg_addr_t       raddr1,
    output logic            pend1,
    input  reg_addr_t       raddr2,
    output logic            pend2,
    output logic [CW-1:0]   lr_count
);

    logic      q_full, q_head_valid, q_head_occ;
    reg_addr_t q_head_addr;
    reg_data_t q_head_data;
    logic      pipe_wr, push, pop;
    logic      we_q, we_d;
    reg_addr_t waddr_q, waddr_d;
    reg_data_t wdata_q, wdata_d;

    assign lr_ready = rst & ~q_full;
    // Writes to r0 are accepted so the producer is not stalled, but dropped.
    assign push     = lr_valid & lr_ready & addr_nonzero(lr_waddr);
    assign pipe_wr  = ~wb_stall & mem_wreg & addr_nonzero(mem_wd);
    // Squashed heads still pop, costing one idle write-port cycle each.
    assign pop      = ~pipe_wr & q_head_occ;

    wb_lr_queue #(.DEPTH(DEPTH)) u_queue (
        .clk             (clk),
        .rst_n           (rst),
        .push_i          (push),
        .push_addr_i     (lr_waddr),
        .push_data_i     (lr_wdata),
        .pop_i           (pop),
        .squash_i        (pipe_wr),
        .squash_addr_i   (mem_wd),
        .match1_addr_i   (raddr1),
        .match2_addr_i   (raddr2),
        .head_valid_o    (q_head_valid),
        .head_occupied_o (q_head_occ),
        .head_addr_o     (q_head_addr),
        .head_data_o     (q_head_data),
        .full_o          (q_full),
        .count_o         (lr_count),
        .match1_o        (pend1),
        .match2_o        (pend2)
    );

    // Priority mux: pipeline, then live queue head; otherwise hold address/data.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (pipe_wr) begin
            we_d    = 1'b1;
            waddr_d = mem_wd;
            wdata_d = mem_wdata;
        end else if (q_head_occ && q_head_valid) begin
            we_d    = 1'b1;
            waddr_d = q_head_addr;
            wdata_d = q_head_data;
        end
    end

    // Registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            waddr_q <= ZERO_ADDR;
            wdata_q <= ZERO_WORD;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: directed scenarios plus random traffic, checked against
// a queue-of-records reference model.
module tb_wb_commit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wreg, wb_stall, lr_valid;
    logic [4:0]  mem_wd, lr_waddr, raddr1, raddr2;
    logic [31:0] mem_wdata, lr_wdata;
    logic        lr_ready, we, pend1, pend2;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  lr_count;

    wb_commit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata), .wb_stall(wb_stall),
        .lr_valid(lr_valid), .lr_waddr(lr_waddr), .lr_wdata(lr_wdata), .lr_ready(lr_ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .pend1(pend1), .raddr2(raddr2), .pend2(pend2),
        .lr_count(lr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        live;
        bit [4:0]  a;
        bit [31:0] d;
    } ent_t;

    ent_t      mq[$];
    bit        exp_we;
    bit [4:0]  exp_waddr;
    bit [31:0] exp_wdata;
    int        n_total = 0;
    int        n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic bit pend_of(input bit [4:0] r);
        if (r == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].live && mq[i].a == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_we    = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
    endtask

    task automatic idle();
        mem_wreg = 1'b0; wb_stall = 1'b0; lr_valid = 1'b0;
        mem_wd = '0; mem_wdata = '0; lr_waddr = '0; lr_wdata = '0;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step();
        bit p, acc;
        ent_t e;
        #1;
        chk("lr_ready", lr_ready, (mq.size() < DEPTH) ? 1 : 0);
        chk("lr_count", lr_count, mq.size());
        chk("pend1", pend1, pend_of(raddr1));
        chk("pend2", pend2, pend_of(raddr2));
        p   = !wb_stall && mem_wreg && mem_wd != 0;
        acc = lr_valid && mq.size() < DEPTH && lr_waddr != 0;
        @(posedge clk);
        if (p) begin
            exp_we = 1; exp_waddr = mem_wd; exp_wdata = mem_wdata;
            foreach (mq[i]) if (mq[i].a == mem_wd) mq[i].live = 0;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            exp_we = e.live;
            if (e.live) begin exp_waddr = e.a; exp_wdata = e.d; end
        end else begin
            exp_we = 0;
        end
        if (acc) mq.push_back('{live: 1'b1, a: lr_waddr, d: lr_wdata});
        #1;
        chk("we", we, exp_we);
        chk("waddr", waddr, exp_waddr);
        chk("wdata", wdata, exp_wdata);
        @(negedge clk);
    endtask

    task automatic pipe(input bit [4:0] r, input bit [31:0] d);
        mem_wreg = 1; mem_wd = r; mem_wdata = d;
    endtask

    task automatic offer(input bit [4:0] r, input bit [31:0] d);
        lr_valid = 1; lr_waddr = r; lr_wdata = d;
    endtask

    initial begin
        idle();
        raddr1 = 0; raddr2 = 0;
        model_reset();

        // 1: reset holds the handshake low even with an offer pending
        rst = 0;
        offer(3, 32'h11);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_lr_ready", lr_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_lr_count", lr_count, 0);
        @(negedge clk);
        rst = 1;
        idle();
        step();

        // 2: pipeline-only writes, including r0
        pipe(5, 32'hDEAD_BEEF); step();
        pipe(0, 32'h1234_5678); step();
        idle(); step();

        // 3: fill queue while the pipeline owns the write port
        for (int i = 1; i <= 5; i++) begin
            pipe(9, 32'h900 + i);
            offer(i[4:0], 32'hA0 + i);
            step();
        end
        idle();
        repeat (5) step();

        // 4: WAW squash of an already-queued entry
        raddr1 = 7; raddr2 = 8;
        offer(7, 1); step();
        offer(8, 2); pipe(9, 32'h99); step();
        idle(); pipe(7, 3); step();
        idle(); repeat (3) step();

        // 5: same-edge enqueue and pipeline write to one register
        raddr1 = 6;
        offer(6, 32'hA); pipe(6, 32'hB); step();
        idle(); step();
        step();

        // 6: async reset with entries queued
        raddr1 = 1; raddr2 = 2;
        pipe(9, 1); offer(1, 1); step();
        offer(2, 2); step();
        offer(3, 3); step();
        idle();
        #2;
        rst = 0;
        #1;
        chk("midrst_we", we, 0);
        chk("midrst_lr_count", lr_count, 0);
        chk("midrst_lr_ready", lr_ready, 0);
        model_reset();
        @(negedge clk);
        rst = 1;
        repeat (4) step();

        // random traffic over a small register range to force collisions
        for (int n = 0; n < 400; n++) begin
            mem_wreg  = $urandom_range(0, 2) == 0;
            wb_stall  = $urandom_range(0, 4) == 0;
            mem_wd    = 5'($urandom_range(0, 7));
            mem_wdata = $urandom;
            lr_valid  = $urandom_range(0, 1) == 1;
            lr_waddr  = 5'($urandom_range(0, 7));
            lr_wdata  = $urandom;
            raddr1    = 5'($urandom_range(0, 7));
            raddr2    = 5'($urandom_range(0, 7));
            step();
        end
        idle();
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
